// File: rtl/fetch_pkg.sv
// Shared constants and FSM state type for the decode-side fetch queue.
package fetch_pkg;
  localparam int unsigned AW_DEF = 10;
  localparam int unsigned IW_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {RUN, DROP} fq_state_e;
endpackage

// File: rtl/fetchq_fifo.sv
// Circular buffer of instruction/address pairs with push, pop and a flush
// that empties it and rewinds both pointers.
module fetchq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10,
  parameter int unsigned IW    = 32
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [IW-1:0]            i_wr_instr,
  input  logic [AW-1:0]            i_wr_addr,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [IW-1:0]            o_rd_instr,
  output logic [AW-1:0]            o_rd_addr
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [IW-1:0]  r_mem_instr [DEPTH];
  logic [AW-1:0]  r_mem_addr  [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem_instr[r_wr_ptr] <= i_wr_instr;
      r_mem_addr[r_wr_ptr]  <= i_wr_addr;
    end
  end

  assign o_count    = r_count;
  assign o_rd_instr = r_mem_instr[r_rd_ptr];
  assign o_rd_addr  = r_mem_addr[r_rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Decode-side fetch receiver: FIFO, decode handshake and redirect FSM.
// Define FETCHQ_SEQ_CHECK_EN to add the sticky seq_err address-sequence flag.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned IW          = IW_DEF,
  parameter int unsigned DROP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   f_valid,
  input  logic [IW-1:0]          f_instr,
  input  logic [AW-1:0]          f_addr,
  output logic                   f_stall,
  output logic                   d_valid,
  output logic [IW-1:0]          d_instr,
  output logic [AW-1:0]          d_addr,
  input  logic                   d_ready,
  input  logic                   redirect_req,
  input  logic [AW-1:0]          redirect_target,
  output logic                   Branch,
  output logic [AW-1:0]          TargetAddress,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCHQ_SEQ_CHECK_EN
  ,
  output logic                   seq_err
`endif
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = (DROP_CYCLES < 1) ? 1 : $clog2(DROP_CYCLES + 1);

  fq_state_e     r_state, w_state_nxt;
  logic [DW-1:0] r_drop_cnt, w_drop_nxt;
  logic          r_branch;
  logic [AW-1:0] r_target;
  logic          w_run, w_push, w_pop, w_empty;
  logic [IW-1:0] w_head_instr;
  logic [AW-1:0] w_head_addr;

  assign w_run   = (r_state == RUN);
  assign w_empty = (count == '0);
  assign f_stall = (count == CW'(DEPTH));
  assign d_valid = !w_empty && w_run;
  assign w_push  = f_valid && !f_stall && w_run && !redirect_req;
  assign w_pop   = d_valid && d_ready && !redirect_req;
  assign d_instr = w_empty ? IW'(NOP_INSTR) : w_head_instr;
  assign d_addr  = w_empty ? '0 : w_head_addr;
  assign Branch        = r_branch;
  assign TargetAddress = r_target;

  fetchq_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_fifo (
    .clk        (clk),
    .i_rst      (Reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (redirect_req),
    .i_wr_instr (f_instr),
    .i_wr_addr  (f_addr),
    .o_count    (count),
    .o_rd_instr (w_head_instr),
    .o_rd_addr  (w_head_addr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop_cnt;
    if (redirect_req) begin
      w_drop_nxt  = DW'(DROP_CYCLES);
      w_state_nxt = (DROP_CYCLES == 0) ? RUN : DROP;
    end else if (r_state == DROP) begin
      if (r_drop_cnt <= DW'(1)) begin
        w_drop_nxt  = '0;
        w_state_nxt = RUN;
      end else begin
        w_drop_nxt = r_drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= RUN;
      r_drop_cnt <= '0;
      r_branch   <= 1'b0;
      r_target   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_branch   <= redirect_req;
      if (redirect_req) r_target <= redirect_target;
    end
  end

`ifdef FETCHQ_SEQ_CHECK_EN
  logic          r_seq_err;
  logic          r_chk_en;
  logic [AW-1:0] r_exp_addr;

  // r_chk_en is clear only for the first push after reset; a redirect arms
  // the check with its target as the expected address.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_seq_err  <= 1'b0;
      r_chk_en   <= 1'b0;
      r_exp_addr <= '0;
    end else if (redirect_req) begin
      r_chk_en   <= 1'b1;
      r_exp_addr <= redirect_target;
    end else if (w_push) begin
      if (r_chk_en && (f_addr != r_exp_addr)) r_seq_err <= 1'b1;
      r_chk_en   <= 1'b1;
      r_exp_addr <= f_addr + 1'b1;
    end
  end

  assign seq_err = r_seq_err;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned IW = 32;
  localparam int unsigned DROP_CYCLES = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic Reset, f_valid, d_ready, redirect_req;
  logic [IW-1:0] f_instr;
  logic [AW-1:0] f_addr, redirect_target;
  logic f_stall, d_valid, Branch;
  logic [IW-1:0] d_instr;
  logic [AW-1:0] d_addr, TargetAddress;
  logic [$clog2(DEPTH):0] count;
`ifdef FETCHQ_SEQ_CHECK_EN
  logic seq_err;
`endif

  fetch_queue #(
    .DEPTH       (DEPTH),
    .AW          (AW),
    .IW          (IW),
    .DROP_CYCLES (DROP_CYCLES)
  ) dut (
    .clk             (clk),
    .Reset           (Reset),
    .f_valid         (f_valid),
    .f_instr         (f_instr),
    .f_addr          (f_addr),
    .f_stall         (f_stall),
    .d_valid         (d_valid),
    .d_instr         (d_instr),
    .d_addr          (d_addr),
    .d_ready         (d_ready),
    .redirect_req    (redirect_req),
    .redirect_target (redirect_target),
    .Branch          (Branch),
    .TargetAddress   (TargetAddress),
    .count           (count)
`ifdef FETCHQ_SEQ_CHECK_EN
    ,
    .seq_err         (seq_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
  } ent_t;

  ent_t          q[$];
  int            m_drop;
  logic          m_branch;
  logic [AW-1:0] m_target;
  logic          m_seq_err, m_seq_have;
  logic [AW-1:0] m_seq_exp;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    bit empty = (q.size() == 0);
    check({ph, ".count"},   64'(count),   64'(q.size()));
    check({ph, ".f_stall"}, 64'(f_stall), 64'(q.size() == DEPTH));
    check({ph, ".d_valid"}, 64'(d_valid), 64'(!empty && m_drop == 0));
    check({ph, ".d_instr"}, 64'(d_instr), empty ? 64'(NOP) : 64'(q[0].instr));
    check({ph, ".d_addr"},  64'(d_addr),  empty ? 64'd0 : 64'(q[0].addr));
    check({ph, ".Branch"},  64'(Branch),  64'(m_branch));
    check({ph, ".Target"},  64'(TargetAddress), 64'(m_target));
`ifdef FETCHQ_SEQ_CHECK_EN
    check({ph, ".seq_err"}, 64'(seq_err), 64'(m_seq_err));
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0;
    m_branch = 1'b0;
    m_target = '0;
    m_seq_err = 1'b0;
    m_seq_have = 1'b0;
    m_seq_exp = '0;
  endtask

  task automatic model_edge(input logic fv, input logic [AW-1:0] fa, input logic [IW-1:0] fi,
                            input logic dr, input logic rr, input logic [AW-1:0] rt);
    bit run = (m_drop == 0);
    bit full = (q.size() == DEPTH);
    if (rr) begin
      q.delete();
      m_branch = 1'b1;
      m_target = rt;
      m_drop = DROP_CYCLES;
      m_seq_have = 1'b1;
      m_seq_exp = rt;
    end else begin
      m_branch = 1'b0;
      if (run && dr && q.size() != 0) void'(q.pop_front());
      if (run && fv && !full) begin
        if (m_seq_have && fa != m_seq_exp) m_seq_err = 1'b1;
        m_seq_have = 1'b1;
        m_seq_exp = fa + 1'b1;
        q.push_back('{instr: fi, addr: fa});
      end
      if (!run) m_drop--;
    end
  endtask

  task automatic step(input string ph, input logic fv, input logic [AW-1:0] fa,
                      input logic [IW-1:0] fi, input logic dr,
                      input logic rr, input logic [AW-1:0] rt);
    f_valid = fv; f_addr = fa; f_instr = fi;
    d_ready = dr; redirect_req = rr; redirect_target = rt;
    #2;
    check_outputs(ph);
    @(posedge clk);
    model_edge(fv, fa, fi, dr, rr, rt);
    #1;
  endtask

  task automatic do_reset(input string ph);
    Reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    Reset = 1'b0;
    f_valid = 1'b0; d_ready = 1'b0; redirect_req = 1'b0;
    #1;
    check_outputs(ph);
  endtask

  initial begin
    logic [AW-1:0] a;
    Reset = 1'b1; f_valid = 1'b0; d_ready = 1'b0; redirect_req = 1'b0;
    f_addr = '0; f_instr = '0; redirect_target = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset");
    check("reset.d_instr_nop", 64'(d_instr), 64'h13);

    // Fill to full; the fifth word must be held off
    for (int i = 0; i < 5; i++)
      step("fill", 1'b1, AW'(i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, '0);
    check("fill.count4", 64'(count), 64'd4);
    check("fill.stall", 64'(f_stall), 64'd1);

    // Drain in order
    for (int i = 0; i < 5; i++) begin
      if (i < 4) check("drain.addr_seq", 64'(d_addr), 64'(i));
      step("drain", 1'b0, '0, '0, 1'b1, 1'b0, '0);
    end
    check("drain.empty_valid", 64'(d_valid), 64'd0);
    check("drain.empty_nop", 64'(d_instr), 64'h13);

    // Redirect with three entries queued
    for (int i = 0; i < 3; i++)
      step("redir_fill", 1'b1, AW'(10'h100 + i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, '0);
    step("redir_req", 1'b1, 10'h103, 32'hBAD0_0000, 1'b0, 1'b1, 10'h040);
    check("redir.count0", 64'(count), 64'd0);
    check("redir.branch1", 64'(Branch), 64'd1);
    check("redir.target", 64'(TargetAddress), 64'h040);
    step("redir_drop", 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    check("redir.branch_pulse", 64'(Branch), 64'd0);
    check("redir.dropped", 64'(count), 64'd0);
    step("redir_new", 1'b1, 10'h040, 32'hC000_0040, 1'b0, 1'b0, '0);
    check("redir.new_head", 64'(d_addr), 64'h040);
    check("redir.target_hold", 64'(TargetAddress), 64'h040);

    // Redirect beats push and pop in the same cycle
    step("prio_req", 1'b1, 10'h041, 32'hC000_0041, 1'b1, 1'b1, 10'h200);
    step("prio_drop", 1'b0, '0, '0, 1'b1, 1'b0, '0);
    check("prio.empty", 64'(count), 64'd0);

    // Back-to-back redirects
    step("b2b_1", 1'b0, '0, '0, 1'b0, 1'b1, 10'h111);
    step("b2b_2", 1'b0, '0, '0, 1'b0, 1'b1, 10'h222);
    check("b2b.branch", 64'(Branch), 64'd1);
    check("b2b.target", 64'(TargetAddress), 64'h222);
    step("b2b_drop", 1'b0, '0, '0, 1'b0, 1'b0, '0);

    // Steady stream at occupancy 2
    a = 10'h222;
    for (int i = 0; i < 2; i++) begin
      step("steady_fill", 1'b1, a, 32'(a) ^ 32'h5555_0000, 1'b0, 1'b0, '0);
      a = a + 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      step("steady", 1'b1, a, 32'(a) ^ 32'h5555_0000, 1'b1, 1'b0, '0);
      a = a + 1'b1;
    end
    check("steady.count2", 64'(count), 64'd2);

    // Randomised traffic, mostly sequential addresses
    for (int i = 0; i < 400; i++) begin
      logic fv, dr, rr;
      logic [AW-1:0] fa, rt;
      fv = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 5);
      rr = ($urandom_range(0, 99) < 5);
      rt = AW'($urandom);
      fa = ($urandom_range(0, 19) == 0) ? AW'($urandom) : a;
      step("rand", fv, fa, $urandom, dr, rr, rt);
      if (rr) a = rt;
      else if (fv && !f_stall && m_drop == 0) a = fa + 1'b1;
    end

    // Reset in the middle of the drop window
    step("rmd_fill", 1'b1, 10'h010, 32'h1, 1'b0, 1'b0, '0);
    step("rmd_req", 1'b1, 10'h011, 32'h2, 1'b0, 1'b1, 10'h300);
    check("rmd.branch_before", 64'(Branch), 64'd1);
    do_reset("rmd_reset");
    check("rmd.branch0", 64'(Branch), 64'd0);
    check("rmd.count0", 64'(count), 64'd0);
    step("rmd_push5", 1'b1, 10'd5, 32'h5, 1'b0, 1'b0, '0);
    check("rmd.run_accepts", 64'(count), 64'd1);
    step("rmd_push7", 1'b1, 10'd7, 32'h7, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++)
      step("rmd_hold", 1'b0, '0, '0, 1'b1, 1'b0, '0);
`ifdef FETCHQ_SEQ_CHECK_EN
    check("seq.sticky", 64'(seq_err), 64'd1);
    step("seq_redir", 1'b0, '0, '0, 1'b0, 1'b1, 10'h050);
    check("seq.sticky_redir", 64'(seq_err), 64'd1);
    do_reset("seq_reset");
    check("seq.cleared", 64'(seq_err), 64'd0);
    step("seq_ok1", 1'b1, 10'h3FE, 32'h1, 1'b1, 1'b0, '0);
    step("seq_ok2", 1'b1, 10'h3FF, 32'h2, 1'b1, 1'b0, '0);
    step("seq_ok3", 1'b1, 10'h000, 32'h3, 1'b1, 1'b0, '0);
    check("seq.wrap_ok", 64'(seq_err), 64'd0);
    step("seq_redir2", 1'b0, '0, '0, 1'b0, 1'b1, 10'h080);
    step("seq_drop2", 1'b0, '0, '0, 1'b0, 1'b0, '0);
    step("seq_badtgt", 1'b1, 10'h081, 32'h4, 1'b0, 1'b0, '0);
    check("seq.target_mismatch", 64'(seq_err), 64'd1);
`endif
    step("final", 1'b0, '0, '0, 1'b1, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
